// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states,
// ALU operation classes and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_EXEC_U   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [2:0] ALU_R   = 3'b000;
    localparam logic [2:0] ALU_I   = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_LUI = 3'b111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // States that hold the memory port until Mem_Ready_i arrives.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory wait state and flags a timeout
// on the cycle the count would reach WAIT_LIMIT; WAIT_LIMIT = 0 never times out.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic timeout
);

    localparam int CW     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam int LAST_I = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    logic [CW-1:0] r_count;

    // Ready in the limit cycle drops waiting, so it beats the timeout.
    assign timeout = (WAIT_LIMIT != 0) && waiting && (r_count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (waiting && !timeout) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style multicycle control FSM: sequences fetch/decode/execute/memory/write-back,
// with a memory ready timeout, sticky fault flags and a retired-instruction counter.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH    = 32,
    parameter int WAIT_LIMIT   = 16,
    parameter int ALU_OP_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              OP_i,
    input  logic                    Mem_Ready_i,
    output logic                    PC_Write_o,
    output logic                    Branch_o,
    output logic                    PC_Source_o,
    output logic                    IorD_o,
    output logic                    Mem_Read_o,
    output logic                    Mem_Write_o,
    output logic                    IR_Write_o,
    output logic [1:0]              Mem_to_Reg_o,
    output logic                    Reg_Write_o,
    output logic [1:0]              ALU_Src_A_o,
    output logic [1:0]              ALU_Src_B_o,
    output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
    output logic                    Illegal_o,
    output logic                    Bus_Err_o,
    output logic [CNT_WIDTH-1:0]    Instr_Count_o,
    output logic [3:0]              State_o
);

    state_t               r_state, w_next;
    logic                 r_illegal, r_busErr;
    logic [CNT_WIDTH-1:0] r_count;

    logic w_waiting, w_clear, w_timeout;
    logic w_retire, w_setIllegal, w_setBusErr;
    logic w_pcWrite, w_branch, w_pcSource, w_iorD, w_memRead, w_memWrite, w_irWrite, w_regWrite;
    logic [1:0] w_memToReg, w_srcA, w_srcB;
    logic [2:0] w_aluOp;

    assign w_waiting = is_wait_state(r_state) && !Mem_Ready_i;
    assign w_clear   = !w_waiting;

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .waiting (w_waiting),
        .timeout (w_timeout)
    );

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_setIllegal = 1'b0;
        w_setBusErr  = 1'b0;
        w_pcWrite    = 1'b0;
        w_branch     = 1'b0;
        w_pcSource   = 1'b0;
        w_iorD       = 1'b0;
        w_memRead    = 1'b0;
        w_memWrite   = 1'b0;
        w_irWrite    = 1'b0;
        w_regWrite   = 1'b0;
        w_memToReg   = WB_ALUOUT;
        w_srcA       = SRC_A_PC;
        w_srcB       = SRC_B_RS2;
        w_aluOp      = ALU_R;
        case (r_state)
            S_FETCH: begin
                w_memRead = 1'b1;
                w_srcB    = SRC_B_FOUR;
                w_aluOp   = ALU_ADD;
                w_irWrite = Mem_Ready_i;
                w_pcWrite = Mem_Ready_i;
                if (Mem_Ready_i) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_setBusErr = 1'b1;
                end
            end
            S_DECODE: begin
                w_srcA  = SRC_A_OLDPC;
                w_srcB  = SRC_B_IMM;
                w_aluOp = ALU_ADD;
                case (OP_i)
                    OP_R:               w_next = S_EXEC_R;
                    OP_I:               w_next = S_EXEC_I;
                    OP_LUI:             w_next = S_EXEC_U;
                    OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
                    OP_BRANCH:          w_next = S_BRANCH;
                    OP_JAL:             w_next = S_JAL;
                    default: begin
                        w_next       = S_TRAP;
                        w_setIllegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                w_srcA  = SRC_A_RS1;
                w_next  = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_srcA  = SRC_A_RS1;
                w_srcB  = SRC_B_IMM;
                w_aluOp = ALU_I;
                w_next  = S_ALU_WB;
            end
            S_EXEC_U: begin
                w_srcB  = SRC_B_IMM;
                w_aluOp = ALU_LUI;
                w_next  = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_regWrite = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_MEM_ADDR: begin
                w_srcA  = SRC_A_RS1;
                w_srcB  = SRC_B_IMM;
                w_aluOp = ALU_ADD;
                w_next  = (OP_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_memRead = 1'b1;
                w_iorD    = 1'b1;
                if (Mem_Ready_i) begin
                    w_next = S_MEM_WB;
                end else if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_setBusErr = 1'b1;
                end
            end
            S_MEM_WB: begin
                w_regWrite = 1'b1;
                w_memToReg = WB_MDR;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_MEM_WR: begin
                w_memWrite = Mem_Ready_i;
                w_iorD     = 1'b1;
                if (Mem_Ready_i) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_setBusErr = 1'b1;
                end
            end
            S_BRANCH: begin
                w_srcA     = SRC_A_RS1;
                w_aluOp    = ALU_SUB;
                w_branch   = 1'b1;
                w_pcSource = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_JAL: begin
                w_pcWrite  = 1'b1;
                w_pcSource = 1'b1;
                w_regWrite = 1'b1;
                w_memToReg = WB_PC;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next       = S_TRAP;
                w_setIllegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_busErr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)     r_count   <= r_count + CNT_WIDTH'(1);
            if (w_setIllegal) r_illegal <= 1'b1;
            if (w_setBusErr)  r_busErr  <= 1'b1;
        end
    end

    // Strobes are gated by reset so nothing fires while it is held low.
    assign PC_Write_o    = w_pcWrite  & reset;
    assign Branch_o      = w_branch   & reset;
    assign IR_Write_o    = w_irWrite  & reset;
    assign Mem_Read_o    = w_memRead  & reset;
    assign Mem_Write_o   = w_memWrite & reset;
    assign Reg_Write_o   = w_regWrite & reset;
    assign PC_Source_o   = w_pcSource;
    assign IorD_o        = w_iorD;
    assign Mem_to_Reg_o  = w_memToReg;
    assign ALU_Src_A_o   = w_srcA;
    assign ALU_Src_B_o   = w_srcB;
    assign ALU_Op_o      = ALU_OP_WIDTH'(w_aluOp);
    assign Illegal_o     = r_illegal;
    assign Bus_Err_o     = r_busErr;
    assign Instr_Count_o = r_count;
    assign State_o       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction state traces built
// from opcode rules, a per-state output table and a retire-count model.
module tb_multicycle_control;

    localparam int CNT_W = 4;
    localparam int WLIM  = 4;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_I      = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    logic             clk;
    logic             reset;
    logic [6:0]       OP_i;
    logic             Mem_Ready_i;
    logic             PC_Write_o, Branch_o, PC_Source_o, IorD_o;
    logic             Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o;
    logic [1:0]       Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o;
    logic [2:0]       ALU_Op_o;
    logic             Illegal_o, Bus_Err_o;
    logic [CNT_W-1:0] Instr_Count_o;
    logic [3:0]       State_o;

    logic [16:0] obsCtl;
    logic [5:0]  obsStrobes;

    int nErrors  = 0;
    int nChecks  = 0;
    int retired  = 0;

    multicycle_control #(
        .CNT_WIDTH    (CNT_W),
        .WAIT_LIMIT   (WLIM),
        .ALU_OP_WIDTH (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .OP_i          (OP_i),
        .Mem_Ready_i   (Mem_Ready_i),
        .PC_Write_o    (PC_Write_o),
        .Branch_o      (Branch_o),
        .PC_Source_o   (PC_Source_o),
        .IorD_o        (IorD_o),
        .Mem_Read_o    (Mem_Read_o),
        .Mem_Write_o   (Mem_Write_o),
        .IR_Write_o    (IR_Write_o),
        .Mem_to_Reg_o  (Mem_to_Reg_o),
        .Reg_Write_o   (Reg_Write_o),
        .ALU_Src_A_o   (ALU_Src_A_o),
        .ALU_Src_B_o   (ALU_Src_B_o),
        .ALU_Op_o      (ALU_Op_o),
        .Illegal_o     (Illegal_o),
        .Bus_Err_o     (Bus_Err_o),
        .Instr_Count_o (Instr_Count_o),
        .State_o       (State_o)
    );

    assign obsCtl = {PC_Write_o, Branch_o, PC_Source_o, IorD_o, Mem_Read_o, Mem_Write_o,
                     IR_Write_o, Mem_to_Reg_o, Reg_Write_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o};
    assign obsStrobes = {PC_Write_o, Branch_o, IR_Write_o, Mem_Read_o, Mem_Write_o, Reg_Write_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word per state, laid out like obsCtl.
    function automatic logic [16:0] expCtl(input int st, input logic rdy);
        logic pcw, br, pcs, iod, mr, mw, irw, rw;
        logic [1:0] m2r, a, b;
        logic [2:0] op;
        {pcw, br, pcs, iod, mr, mw, irw, rw} = '0;
        m2r = 2'b00; a = 2'b00; b = 2'b00; op = 3'b000;
        case (st)
            0:  begin mr = 1; irw = rdy; pcw = rdy; b = 2'b01; op = 3'b010; end
            1:  begin a = 2'b10; b = 2'b10; op = 3'b010; end
            2:  begin a = 2'b01; b = 2'b00; op = 3'b000; end
            3:  begin a = 2'b01; b = 2'b10; op = 3'b001; end
            4:  begin b = 2'b10; op = 3'b111; end
            5:  begin rw = 1; m2r = 2'b00; end
            6:  begin a = 2'b01; b = 2'b10; op = 3'b010; end
            7:  begin mr = 1; iod = 1; end
            8:  begin rw = 1; m2r = 2'b01; end
            9:  begin mw = rdy; iod = 1; end
            10: begin a = 2'b01; b = 2'b00; op = 3'b011; br = 1; pcs = 1; end
            11: begin pcw = 1; pcs = 1; rw = 1; m2r = 2'b10; end
            default: ;
        endcase
        return {pcw, br, pcs, iod, mr, mw, irw, m2r, rw, a, b, op};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Begins and ends on a falling edge; reset is released on a falling edge.
    task automatic do_reset();
        reset       = 1'b0;
        Mem_Ready_i = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        retired = 0;
    endtask

    // Executes one instruction: fw not-ready fetch cycles, mw not-ready memory cycles.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        int stQ[$];
        int rdQ[$];
        logic rdy;
        for (int i = 0; i < fw; i++) begin stQ.push_back(0); rdQ.push_back(0); end
        stQ.push_back(0); rdQ.push_back(1);
        stQ.push_back(1); rdQ.push_back(2);
        case (op)
            OPC_R:      begin stQ.push_back(2); rdQ.push_back(2); stQ.push_back(5); rdQ.push_back(2); end
            OPC_I:      begin stQ.push_back(3); rdQ.push_back(2); stQ.push_back(5); rdQ.push_back(2); end
            OPC_LUI:    begin stQ.push_back(4); rdQ.push_back(2); stQ.push_back(5); rdQ.push_back(2); end
            OPC_LOAD: begin
                stQ.push_back(6); rdQ.push_back(2);
                for (int i = 0; i < mw; i++) begin stQ.push_back(7); rdQ.push_back(0); end
                stQ.push_back(7); rdQ.push_back(1);
                stQ.push_back(8); rdQ.push_back(2);
            end
            OPC_STORE: begin
                stQ.push_back(6); rdQ.push_back(2);
                for (int i = 0; i < mw; i++) begin stQ.push_back(9); rdQ.push_back(0); end
                stQ.push_back(9); rdQ.push_back(1);
            end
            OPC_BRANCH: begin stQ.push_back(10); rdQ.push_back(2); end
            default:    begin stQ.push_back(11); rdQ.push_back(2); end
        endcase
        for (int k = 0; k < stQ.size(); k++) begin
            rdy = (rdQ[k] == 2) ? rnd_bit() : (rdQ[k] == 1);
            OP_i        = op;
            Mem_Ready_i = rdy;
            #1;
            nChecks++;
            if (State_o !== 4'(stQ[k])) begin
                nErrors++;
                $display("[TB] FAIL state op=%h step=%0d: got %0d expected %0d", op, k, State_o, stQ[k]);
            end
            nChecks++;
            if (obsCtl !== expCtl(stQ[k], rdy)) begin
                nErrors++;
                $display("[TB] FAIL ctl op=%h st=%0d rdy=%0b: got %h expected %h", op, stQ[k], rdy, obsCtl, expCtl(stQ[k], rdy));
            end
            nChecks++;
            if (Instr_Count_o !== 4'(retired % 16)) begin
                nErrors++;
                $display("[TB] FAIL count op=%h step=%0d: got %0d expected %0d", op, k, Instr_Count_o, retired % 16);
            end
            nChecks++;
            if ({Illegal_o, Bus_Err_o} !== 2'b00) begin
                nErrors++;
                $display("[TB] FAIL flags op=%h step=%0d: got %b expected 00", op, k, {Illegal_o, Bus_Err_o});
            end
            @(negedge clk);
        end
        retired++;
        nChecks++;
        if (State_o !== 4'd0 || Instr_Count_o !== 4'(retired % 16)) begin
            nErrors++;
            $display("[TB] FAIL retire op=%h: got state %0d count %0d expected 0 / %0d", op, State_o, Instr_Count_o, retired % 16);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        Mem_Ready_i = 1'b1;
        OP_i        = OPC_R;
        #1 reset = 1'b0;
        #1;
        nChecks++;
        if (State_o !== 4'd0 || Instr_Count_o !== 4'd0) begin
            nErrors++;
            $display("[TB] FAIL reset_state: got state %0d count %0d expected 0/0", State_o, Instr_Count_o);
        end
        nChecks++;
        if ({Illegal_o, Bus_Err_o} !== 2'b00) begin
            nErrors++;
            $display("[TB] FAIL reset_flags: got %b expected 00", {Illegal_o, Bus_Err_o});
        end
        nChecks++;
        if (obsStrobes !== 6'b0) begin
            nErrors++;
            $display("[TB] FAIL reset_strobes: got %b expected 000000", obsStrobes);
        end
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b1;
        retired = 0;
    endtask

    task automatic test_rtype();
        do_reset();
        run_instr(OPC_R, 0, 0);
        nChecks++;
        if (Instr_Count_o !== 4'd1) begin
            nErrors++;
            $display("[TB] FAIL rtype_count: got %0d expected 1", Instr_Count_o);
        end
        run_instr(OPC_I, 0, 0);
        run_instr(OPC_LUI, 2, 0);
    endtask

    task automatic test_load_slow();
        do_reset();
        run_instr(OPC_LOAD, 0, 3);
        run_instr(OPC_STORE, 1, 2);
    endtask

    task automatic test_jal_branch();
        do_reset();
        run_instr(OPC_JAL, 0, 0);
        run_instr(OPC_BRANCH, 1, 0);
    endtask

    task automatic test_timeout();
        int   seqSt[7] = '{0, 1, 6, 7, 7, 7, 7};
        logic seqRd[7] = '{1, 1, 1, 0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < WLIM; i++) begin
            Mem_Ready_i = 1'b0;
            #1;
            nChecks++;
            if (State_o !== 4'd0) begin
                nErrors++;
                $display("[TB] FAIL fetch_wait cyc=%0d: got state %0d expected 0", i, State_o);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            Mem_Ready_i = 1'b1;
            #1;
            nChecks++;
            if (State_o !== 4'd12 || Bus_Err_o !== 1'b1 || Illegal_o !== 1'b0) begin
                nErrors++;
                $display("[TB] FAIL fetch_timeout cyc=%0d: got state %0d buserr %b illegal %b expected 12/1/0", i, State_o, Bus_Err_o, Illegal_o);
            end
            nChecks++;
            if (obsCtl !== 17'd0 || Instr_Count_o !== 4'd0) begin
                nErrors++;
                $display("[TB] FAIL trap_outputs cyc=%0d: got ctl %h count %0d expected 0/0", i, obsCtl, Instr_Count_o);
            end
            @(negedge clk);
        end
        do_reset();
        run_instr(OPC_R, WLIM - 1, 0);
        do_reset();
        OP_i = OPC_LOAD;
        for (int i = 0; i < 7; i++) begin
            Mem_Ready_i = seqRd[i];
            #1;
            nChecks++;
            if (State_o !== 4'(seqSt[i]) || obsCtl !== expCtl(seqSt[i], seqRd[i])) begin
                nErrors++;
                $display("[TB] FAIL memrd_wait cyc=%0d: got state %0d ctl %h expected %0d / %h", i, State_o, obsCtl, seqSt[i], expCtl(seqSt[i], seqRd[i]));
            end
            @(negedge clk);
        end
        Mem_Ready_i = 1'b1;
        #1;
        nChecks++;
        if (State_o !== 4'd12 || Bus_Err_o !== 1'b1 || obsCtl !== 17'd0) begin
            nErrors++;
            $display("[TB] FAIL memrd_timeout: got state %0d buserr %b ctl %h expected 12/1/0", State_o, Bus_Err_o, obsCtl);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        do_reset();
        OP_i        = 7'h7F;
        Mem_Ready_i = 1'b1;
        @(negedge clk);
        nChecks++;
        if (State_o !== 4'd1 || Illegal_o !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL illegal_decode: got state %0d illegal %b expected 1/0", State_o, Illegal_o);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            Mem_Ready_i = rnd_bit();
            #1;
            nChecks++;
            if (State_o !== 4'd12 || Illegal_o !== 1'b1 || Bus_Err_o !== 1'b0 || obsCtl !== 17'd0) begin
                nErrors++;
                $display("[TB] FAIL illegal_trap cyc=%0d: got state %0d illegal %b buserr %b ctl %h expected 12/1/0/0", i, State_o, Illegal_o, Bus_Err_o, obsCtl);
            end
        end
        reset = 1'b0;
        #1;
        nChecks++;
        if (State_o !== 4'd0 || Illegal_o !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL illegal_clear: got state %0d illegal %b expected 0/0", State_o, Illegal_o);
        end
        @(negedge clk);
        reset   = 1'b1;
        retired = 0;
    endtask

    task automatic test_wrap();
        logic [6:0] ops[7] = '{OPC_R, OPC_I, OPC_LUI, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL};
        do_reset();
        for (int n = 0; n < 17; n++)
            run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, WLIM - 1), $urandom_range(0, WLIM - 1));
        nChecks++;
        if (Instr_Count_o !== 4'd1) begin
            nErrors++;
            $display("[TB] FAIL wrap_count: got %0d expected 1", Instr_Count_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[7] = '{OPC_R, OPC_I, OPC_LUI, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL};
        for (int n = 0; n < 30; n++)
            run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, WLIM - 1), $urandom_range(0, WLIM - 1));
    endtask

    task automatic test_reset_mid();
        int   seqSt[5] = '{0, 1, 6, 9, 9};
        logic seqRd[5] = '{1, 0, 1, 0, 0};
        do_reset();
        run_instr(OPC_R, 0, 0);
        OP_i = OPC_STORE;
        for (int i = 0; i < 5; i++) begin
            Mem_Ready_i = seqRd[i];
            #1;
            nChecks++;
            if (State_o !== 4'(seqSt[i])) begin
                nErrors++;
                $display("[TB] FAIL store_seq cyc=%0d: got state %0d expected %0d", i, State_o, seqSt[i]);
            end
            @(negedge clk);
        end
        Mem_Ready_i = 1'b1;
        #1;
        nChecks++;
        if (State_o !== 4'd9 || Mem_Write_o !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL store_ready: got state %0d memwrite %b expected 9/1", State_o, Mem_Write_o);
        end
        #1 reset = 1'b0;
        #1;
        nChecks++;
        if (Mem_Write_o !== 1'b0 || State_o !== 4'd0 || obsStrobes !== 6'b0 || Instr_Count_o !== 4'd0) begin
            nErrors++;
            $display("[TB] FAIL midreset: got memwrite %b state %0d strobes %b count %0d expected 0/0/0/0", Mem_Write_o, State_o, obsStrobes, Instr_Count_o);
        end
        @(negedge clk);
        reset   = 1'b1;
        retired = 0;
        run_instr(OPC_I, 0, 0);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_slow();
        test_jal_branch();
        test_timeout();
        test_illegal();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control unit for the RISC-V core; next generation of the single-cycle opcode decoder.
- A Moore FSM sequences fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one memory port.
- Adds a memory ready handshake with a timeout, a sticky fault/trap state, and a retired-instruction counter.
- Sits between the instruction register opcode field and the multicycle datapath muxes and enables.

Parameters:
- CNT_WIDTH, 32: width of the retired-instruction counter.
- WAIT_LIMIT, 16: maximum number of cycles spent waiting for Mem_Ready_i in one memory state. 0 disables the timeout.
- ALU_OP_WIDTH, 3: width of ALU_Op_o. Codes are defined in the package.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OP_i  in  7  opcode field from the instruction register.
- Mem_Ready_i  in  1  memory completes the current access this cycle.
- PC_Write_o  out  1  unconditional PC write.
- Branch_o  out  1  conditional PC write; the datapath ANDs it with ALU zero.
- PC_Source_o  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- IorD_o  out  1  memory address: 0 = PC, 1 = ALUOut.
- Mem_Read_o  out  1  memory read strobe.
- Mem_Write_o  out  1  memory write strobe.
- IR_Write_o  out  1  instruction register load.
- Mem_to_Reg_o  out  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC.
- Reg_Write_o  out  1  register file write.
- ALU_Src_A_o  out  2  ALU input A: 00 = PC, 01 = rs1, 10 = OldPC.
- ALU_Src_B_o  out  2  ALU input B: 00 = rs2, 01 = constant 4, 10 = immediate.
- ALU_Op_o  out  ALU_OP_WIDTH  ALU operation class.
- Illegal_o  out  1  sticky: unknown opcode.
- Bus_Err_o  out  1  sticky: memory timeout.
- Instr_Count_o  out  CNT_WIDTH  count of retired instructions.
- State_o  out  4  current state, for debug.

Behaviour:
- Reset: reset low asynchronously sets state = FETCH, wait counter = 0, Instr_Count_o = 0, Illegal_o = 0, Bus_Err_o = 0.
- While reset is low, every strobe output (PC_Write, Branch, IR_Write, Mem_Read, Mem_Write, Reg_Write) is forced to 0.
- Reset mid-operation abandons the current instruction with no further strobes.
- Outputs are a combinational Moore decode of state. The only exception is that write strobes in wait states are qualified by Mem_Ready_i.
- Unlisted outputs are 0 in every state.
- ALU_Op codes: R = 000, I = 001, ADD = 010, SUB = 011, LUI = 111.
- Opcodes: R = 0x33, I = 0x13, LUI = 0x37, LOAD = 0x03, STORE = 0x23, BRANCH = 0x63, JAL = 0x6F.
- States, transitions and outputs:
  - FETCH (0): Mem_Read = 1, IorD = 0, A = 00, B = 01, ALU_Op = ADD. IR_Write and PC_Write equal Mem_Ready_i. Ready goes to DECODE; otherwise stay.
  - DECODE (1): A = 10, B = 10, ALU_Op = ADD (branch/jump target into ALUOut). Next state by OP_i: R → EXEC_R, I → EXEC_I, LUI → EXEC_U, LOAD/STORE → MEM_ADDR, BRANCH → BRANCH, JAL → JAL. Any other opcode → TRAP and sets Illegal_o.
  - EXEC_R (2): A = 01, B = 00, ALU_Op = R → ALU_WB.
  - EXEC_I (3): A = 01, B = 10, ALU_Op = I → ALU_WB.
  - EXEC_U (4): B = 10, ALU_Op = LUI → ALU_WB.
  - ALU_WB (5): Reg_Write = 1, Mem_to_Reg = 00 → FETCH (retire).
  - MEM_ADDR (6): A = 01, B = 10, ALU_Op = ADD → MEM_RD for LOAD, MEM_WR for STORE. OP_i is stable from the IR.
  - MEM_RD (7): Mem_Read = 1, IorD = 1. Ready goes to MEM_WB; otherwise stay.
  - MEM_WB (8): Reg_Write = 1, Mem_to_Reg = 01 → FETCH (retire).
  - MEM_WR (9): Mem_Write = Mem_Ready_i, IorD = 1. Ready goes to FETCH (retire).
  - BRANCH (10): A = 01, B = 00, ALU_Op = SUB, Branch_o = 1, PC_Source = 1 → FETCH (retire).
  - JAL (11): PC_Write = 1, PC_Source = 1, Reg_Write = 1, Mem_to_Reg = 10 → FETCH (retire).
  - TRAP (12): all strobes 0. Stays until reset.
- Wait timer:
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in those states while Mem_Ready_i = 0.
  - If WAIT_LIMIT ≠ 0 and the count reaches WAIT_LIMIT with ready still 0, go to TRAP and set Bus_Err_o.
  - Ready arriving in the same cycle the limit is reached wins: no error.
- Retire: Instr_Count_o increments by 1 on each retire transition and wraps modulo 2^CNT_WIDTH. TRAP never retires.
- State codes 13–15 are unreachable; if entered, go to TRAP with Illegal_o = 1.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode localparams;
  - state encodings;
  - ALU_Op codes;
  - mux select encodings for ALU_Src_A, ALU_Src_B and Mem_to_Reg.
- Sub-module mem_wait_timer (parameter WAIT_LIMIT).
  - Inputs: clk, reset, clear, waiting.
  - Output: timeout.

Test Plan:
- R-type: release reset, OP_i = 0x33, Mem_Ready_i = 1 → states 0,1,2,5,0. Reg_Write = 1 only in state 5. Instr_Count_o = 1 after 4 cycles.
- Load with slow memory: OP_i = 0x03, ready low for 3 cycles in MEM_RD → Mem_Read held for 4 cycles, then MEM_WB with Mem_to_Reg = 01 and Reg_Write = 1. Count +1.
- Timeout: WAIT_LIMIT = 4, ready held low in FETCH → TRAP after 4 cycles, Bus_Err_o = 1, strobes 0, count frozen. Ready at cycle 4 → no error.
- Illegal opcode: OP_i = 0x7F → DECODE then TRAP, Illegal_o = 1, held indefinitely. Reset low → FETCH, flags cleared.
- JAL/BRANCH: 0x6F → JAL with PC_Write = 1, PC_Source = 1, Mem_to_Reg = 10. 0x63 → Branch_o = 1, ALU_Op = 011, PC_Write = 0.
- Wrap/reset: CNT_WIDTH = 4, retire 17 instructions → Instr_Count_o = 1. Assert reset during MEM_WR → Mem_Write drops immediately, state = 0.
